// File: rtl/program_loader.sv
// rtl/program_loader.sv - boot loader: length-prefixed UART byte stream into instruction memory words
module program_loader #(
  parameter int BUF_BIT_WIDTH = 16,
  parameter int MEM_BIT_WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [BUF_BIT_WIDTH-1:0] uart_buf_len,
  output logic                     uart_out_valid,
  input  logic                     uart_out_ready,
  input  logic [7:0]               uart_out_data,
  output logic [31:0]              mem_in_addr,
  output logic [31:0]              mem_in_data,
  output logic                     mem_in_valid,
  input  logic                     mem_in_ready,
  output logic                     load_completed,
  output logic                     load_error,
  output logic [31:0]              word_count
);

  localparam logic [31:0] MAX_WORDS = 32'd1 << (MEM_BIT_WIDTH - 2);

  typedef enum logic [2:0] {
    S_LEN,
    S_DATA,
    S_WRITE,
    S_DONE,
    S_ERROR
  } state_t;

  state_t      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [31:0] len_q, len_d;
  logic [31:0] word_q, word_d;
  logic [31:0] idx_q, idx_d;
  logic        uart_valid_q, uart_valid_d;
  logic        mem_valid_q, mem_valid_d;

  logic        byte_taken;
  logic [31:0] gathered;
  logic [31:0] idx_next;

  always_comb begin
    state_d      = state_q;
    byte_cnt_d   = byte_cnt_q;
    len_d        = len_q;
    word_d       = word_q;
    idx_d        = idx_q;
    uart_valid_d = uart_valid_q;
    mem_valid_d  = mem_valid_q;

    byte_taken = uart_valid_q && uart_out_ready;
    idx_next   = idx_q + 32'd1;
    gathered   = (state_q == S_LEN) ? len_q : word_q;
    gathered[{byte_cnt_q, 3'b000} +: 8] = uart_out_data;

    case (state_q)
      S_LEN, S_DATA: begin
        if (byte_taken) begin
          // Dropping valid here yields the mandatory idle cycle between requests.
          uart_valid_d = 1'b0;
          byte_cnt_d   = byte_cnt_q + 2'd1;
          if (state_q == S_LEN) len_d = gathered;
          else                  word_d = gathered;
          if (byte_cnt_q == 2'd3) begin
            byte_cnt_d = 2'd0;
            if (state_q == S_LEN) begin
              if (gathered == 32'd0)           state_d = S_DONE;
              else if (gathered > MAX_WORDS)   state_d = S_ERROR;
              else                             state_d = S_DATA;
            end else begin
              state_d     = S_WRITE;
              mem_valid_d = 1'b1;
            end
          end
        end else if (!uart_valid_q && (uart_buf_len != '0)) begin
          uart_valid_d = 1'b1;
        end
      end
      S_WRITE: begin
        if (mem_valid_q && mem_in_ready) begin
          mem_valid_d = 1'b0;
          idx_d       = idx_next;
          state_d     = (idx_next == len_q) ? S_DONE : S_DATA;
        end
      end
      default: begin
        uart_valid_d = 1'b0;
        mem_valid_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= S_LEN;
      byte_cnt_q   <= 2'd0;
      len_q        <= 32'd0;
      word_q       <= 32'd0;
      idx_q        <= 32'd0;
      uart_valid_q <= 1'b0;
      mem_valid_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      byte_cnt_q   <= byte_cnt_d;
      len_q        <= len_d;
      word_q       <= word_d;
      idx_q        <= idx_d;
      uart_valid_q <= uart_valid_d;
      mem_valid_q  <= mem_valid_d;
    end
  end

  assign uart_out_valid = uart_valid_q;
  assign mem_in_valid   = mem_valid_q;
  assign mem_in_addr    = {idx_q[29:0], 2'b00};
  assign mem_in_data    = word_q;
  assign word_count     = idx_q;
  assign load_completed = (state_q == S_DONE);
  assign load_error     = (state_q == S_ERROR);

endmodule

// File: tb/tb_program_loader.sv
// tb/tb_program_loader.sv - directed self-checking bench for program_loader
module tb_program_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [15:0] uart_buf_len = 16'd0;
  logic        uart_out_valid;
  logic        uart_out_ready = 1'b0;
  logic [7:0]  uart_out_data = 8'h00;
  logic [31:0] mem_in_addr;
  logic [31:0] mem_in_data;
  logic        mem_in_valid;
  logic        mem_in_ready = 1'b0;
  logic        load_completed;
  logic        load_error;
  logic [31:0] word_count;

  int errors = 0;
  int checks = 0;
  int wr_cnt = 0;

  program_loader #(.BUF_BIT_WIDTH(16), .MEM_BIT_WIDTH(16)) dut (
    .clk(clk), .reset(reset), .uart_buf_len(uart_buf_len),
    .uart_out_valid(uart_out_valid), .uart_out_ready(uart_out_ready), .uart_out_data(uart_out_data),
    .mem_in_addr(mem_in_addr), .mem_in_data(mem_in_data), .mem_in_valid(mem_in_valid),
    .mem_in_ready(mem_in_ready), .load_completed(load_completed), .load_error(load_error),
    .word_count(word_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (reset && mem_in_valid && mem_in_ready) wr_cnt++;

  task automatic do_reset();
    reset = 1'b0;
    uart_out_ready = 1'b0;
    mem_in_ready = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n = 0;
    @(negedge clk);
    while (uart_out_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    if (n >= 100) begin
      checks++; errors++;
      $display("FAIL uart_request_timeout: no uart_out_valid within 100 cycles (byte %h)", b);
    end
    uart_out_data = b;
    uart_out_ready = 1'b1;
    @(posedge clk); #1;
    uart_out_ready = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    send_byte(w[7:0]); send_byte(w[15:8]); send_byte(w[23:16]); send_byte(w[31:24]);
  endtask

  task automatic mem_write(input logic [31:0] exp_addr, input logic [31:0] exp_data);
    int n = 0;
    @(negedge clk);
    while (mem_in_valid !== 1'b1 && n < 100) begin @(negedge clk); n++; end
    checks++;
    if (n >= 100) begin
      errors++; $display("FAIL mem_write_timeout: no mem_in_valid within 100 cycles (addr %h)", exp_addr);
    end
    checks++;
    if (mem_in_addr !== exp_addr) begin
      errors++; $display("FAIL mem_addr: got %h expected %h", mem_in_addr, exp_addr);
    end
    checks++;
    if (mem_in_data !== exp_data) begin
      errors++; $display("FAIL mem_data: got %h expected %h", mem_in_data, exp_data);
    end
    mem_in_ready = 1'b1;
    @(posedge clk); #1;
    mem_in_ready = 1'b0;
    checks++;
    if (mem_in_valid !== 1'b0) begin
      errors++; $display("FAIL mem_valid_drop: got %b expected 0", mem_in_valid);
    end
  endtask

  task automatic test_reset();
    int bad = 0;
    uart_buf_len = 16'd0;
    do_reset();
    checks++; if (uart_out_valid !== 1'b0) begin errors++; $display("FAIL rst_uart_valid: got %b expected 0", uart_out_valid); end
    checks++; if (mem_in_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_valid: got %b expected 0", mem_in_valid); end
    checks++; if (mem_in_addr !== 32'd0) begin errors++; $display("FAIL rst_mem_addr: got %h expected 0", mem_in_addr); end
    checks++; if (mem_in_data !== 32'd0) begin errors++; $display("FAIL rst_mem_data: got %h expected 0", mem_in_data); end
    checks++; if (load_completed !== 1'b0) begin errors++; $display("FAIL rst_completed: got %b expected 0", load_completed); end
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL rst_error: got %b expected 0", load_error); end
    checks++; if (word_count !== 32'd0) begin errors++; $display("FAIL rst_word_count: got %0d expected 0", word_count); end
    for (int i = 0; i < 5; i++) begin @(negedge clk); if (uart_out_valid !== 1'b0) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL empty_buf_no_request: %0d request cycles expected 0", bad); end
  endtask

  task automatic test_empty_image();
    int bad = 0;
    int w0;
    do_reset();
    w0 = wr_cnt;
    uart_buf_len = 16'd4;
    send_word(32'h0000_0000);
    checks++; if (load_completed !== 1'b1) begin errors++; $display("FAIL empty_completed: got %b expected 1", load_completed); end
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL empty_error: got %b expected 0", load_error); end
    for (int i = 0; i < 10; i++) begin @(negedge clk); if (uart_out_valid !== 1'b0 || mem_in_valid !== 1'b0) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL empty_idle: %0d active cycles expected 0", bad); end
    checks++; if (wr_cnt - w0 != 0) begin errors++; $display("FAIL empty_writes: got %0d expected 0", wr_cnt - w0); end
    checks++; if (word_count !== 32'd0) begin errors++; $display("FAIL empty_word_count: got %0d expected 0", word_count); end
  endtask

  task automatic test_two_words();
    int w0;
    do_reset();
    w0 = wr_cnt;
    uart_buf_len = 16'd12;
    send_word(32'h0000_0002);
    send_word(32'h1122_3344);
    mem_write(32'd0, 32'h1122_3344);
    checks++; if (load_completed !== 1'b0) begin errors++; $display("FAIL two_early_completed: got %b expected 0", load_completed); end
    checks++; if (word_count !== 32'd1) begin errors++; $display("FAIL two_word_count_mid: got %0d expected 1", word_count); end
    send_word(32'hDEAD_BEEF);
    mem_write(32'd4, 32'hDEAD_BEEF);
    checks++; if (load_completed !== 1'b1) begin errors++; $display("FAIL two_completed: got %b expected 1", load_completed); end
    checks++; if (word_count !== 32'd2) begin errors++; $display("FAIL two_word_count: got %0d expected 2", word_count); end
    checks++; if (wr_cnt - w0 != 2) begin errors++; $display("FAIL two_writes: got %0d expected 2", wr_cnt - w0); end
  endtask

  task automatic test_starvation();
    int bad = 0;
    do_reset();
    uart_buf_len = 16'd6;
    send_word(32'h0000_0001);
    send_byte(8'h78);
    send_byte(8'h56);
    uart_buf_len = 16'd0;
    uart_out_ready = 1'b1;
    uart_out_data = 8'hFF;
    for (int i = 0; i < 50; i++) begin @(negedge clk); if (uart_out_valid !== 1'b0 || mem_in_valid !== 1'b0) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL starve_idle: %0d active cycles expected 0", bad); end
    uart_out_ready = 1'b0;
    uart_buf_len = 16'd2;
    send_byte(8'h34);
    send_byte(8'h12);
    mem_write(32'd0, 32'h1234_5678);
    checks++; if (load_completed !== 1'b1) begin errors++; $display("FAIL starve_completed: got %b expected 1", load_completed); end
  endtask

  task automatic test_back_pressure();
    int bad = 0;
    int w0;
    do_reset();
    w0 = wr_cnt;
    uart_buf_len = 16'd8;
    send_word(32'h0000_0001);
    send_word(32'hCAFE_F00D);
    checks++; if (mem_in_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_rise: got %b expected 1", mem_in_valid); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (mem_in_valid !== 1'b1 || mem_in_addr !== 32'd0 || mem_in_data !== 32'hCAFE_F00D || uart_out_valid !== 1'b0) bad++;
    end
    checks++; if (bad != 0) begin errors++; $display("FAIL bp_stable: %0d unstable cycles expected 0", bad); end
    mem_in_ready = 1'b1;
    @(posedge clk); #1;
    mem_in_ready = 1'b0;
    checks++; if (mem_in_valid !== 1'b0) begin errors++; $display("FAIL bp_valid_drop: got %b expected 0", mem_in_valid); end
    checks++; if (load_completed !== 1'b1) begin errors++; $display("FAIL bp_completed: got %b expected 1", load_completed); end
    repeat (5) @(negedge clk);
    checks++; if (wr_cnt - w0 != 1) begin errors++; $display("FAIL bp_writes: got %0d expected 1", wr_cnt - w0); end
  endtask

  task automatic test_oversize();
    int bad = 0;
    int w0;
    do_reset();
    w0 = wr_cnt;
    uart_buf_len = 16'd8;
    send_word(32'h0000_4001);
    checks++; if (load_error !== 1'b1) begin errors++; $display("FAIL over_error: got %b expected 1", load_error); end
    checks++; if (load_completed !== 1'b0) begin errors++; $display("FAIL over_completed: got %b expected 0", load_completed); end
    for (int i = 0; i < 20; i++) begin @(negedge clk); if (uart_out_valid !== 1'b0 || mem_in_valid !== 1'b0) bad++; end
    checks++; if (bad != 0) begin errors++; $display("FAIL over_idle: %0d active cycles expected 0", bad); end
    checks++; if (wr_cnt - w0 != 0) begin errors++; $display("FAIL over_writes: got %0d expected 0", wr_cnt - w0); end
    do_reset();
    send_word(32'h0000_4000);
    checks++; if (load_error !== 1'b0) begin errors++; $display("FAIL max_len_error: got %b expected 0", load_error); end
    @(negedge clk); @(negedge clk);
    checks++; if (uart_out_valid !== 1'b1) begin errors++; $display("FAIL max_len_data_request: got %b expected 1", uart_out_valid); end
  endtask

  task automatic test_reset_mid_word();
    do_reset();
    uart_buf_len = 16'd12;
    send_word(32'h0000_0002);
    send_word(32'h0102_0304);
    mem_write(32'd0, 32'h0102_0304);
    send_byte(8'h11);
    send_byte(8'h22);
    @(negedge clk); @(negedge clk);
    checks++; if (uart_out_valid !== 1'b1) begin errors++; $display("FAIL mid_pending_request: got %b expected 1", uart_out_valid); end
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    checks++; if (uart_out_valid !== 1'b0) begin errors++; $display("FAIL mid_uart_valid: got %b expected 0", uart_out_valid); end
    checks++; if (mem_in_addr !== 32'd0) begin errors++; $display("FAIL mid_mem_addr: got %h expected 0", mem_in_addr); end
    checks++; if (mem_in_data !== 32'd0) begin errors++; $display("FAIL mid_mem_data: got %h expected 0", mem_in_data); end
    checks++; if (word_count !== 32'd0) begin errors++; $display("FAIL mid_word_count: got %0d expected 0", word_count); end
    checks++; if (mem_in_valid !== 1'b0 || load_completed !== 1'b0 || load_error !== 1'b0)
      begin errors++; $display("FAIL mid_flags: got v=%b c=%b e=%b expected 0 0 0", mem_in_valid, load_completed, load_error); end
    send_word(32'h0000_0001);
    send_word(32'hDDCC_BBAA);
    mem_write(32'd0, 32'hDDCC_BBAA);
    checks++; if (load_completed !== 1'b1) begin errors++; $display("FAIL mid_completed: got %b expected 1", load_completed); end
    checks++; if (word_count !== 32'd1) begin errors++; $display("FAIL mid_final_count: got %0d expected 1", word_count); end
  endtask

  initial begin
    test_reset();
    test_empty_image();
    test_two_words();
    test_starvation();
    test_back_pressure();
    test_oversize();
    test_reset_mid_word();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_loader.md
# program_loader

Hardware boot loader between the host-facing UART receiver and the instruction memory. It pulls a length-prefixed little-endian program image byte-by-byte from the UART receive buffer and writes it word-by-word into instruction memory from address 0. It then asserts `load_completed`, which releases the core, main memory and UART from reset.

## Interface
- `BUF_BIT_WIDTH`, 16: width of the UART receive-buffer length input.
- `MEM_BIT_WIDTH`, 16: instruction-memory byte-address width; maximum program size `MAX_WORDS = 2**(MEM_BIT_WIDTH-2)`.

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-low: 0 = reset.
- `uart_buf_len`  in  BUF_BIT_WIDTH  bytes waiting in the UART receive buffer.
- `uart_out_valid`  out  1  read request to the UART.
- `uart_out_ready`  in  1  UART response; `uart_out_data` is valid in this cycle.
- `uart_out_data`  in  8  received byte.
- `mem_in_addr`  out  32  instruction-memory write byte address.
- `mem_in_data`  out  32  instruction-memory write data.
- `mem_in_valid`  out  1  write request.
- `mem_in_ready`  in  1  write accepted.
- `load_completed`  out  1  image fully written; sticky until reset.
- `load_error`  out  1  declared length exceeds `MAX_WORDS`; sticky until reset.
- `word_count`  out  32  number of words written so far.

## Operation
- Stream format:
  - bytes 0..3: word count N, little-endian.
  - followed by 4N bytes: each word little-endian.
  - byte k of a group lands in bits [8k+7:8k].
- States:
  - LEN: gather 4 bytes into N.
  - DATA: gather 4 bytes into the word register.
  - WRITE: present the word to instruction memory.
  - DONE.
  - ERROR.
- Transitions:
  - Reset → LEN.
  - LEN, 4th byte captured:
    - N == 0 → DONE.
    - N > MAX_WORDS → ERROR.
    - otherwise → DATA.
  - DATA, 4th byte captured → WRITE.
  - WRITE, `mem_in_ready` seen:
    - increment the word index.
    - index == N → DONE.
    - otherwise → DATA.
  - DONE and ERROR are terminal until reset. They issue no further UART reads and no memory writes.
- Write address is 4 × word index, giving 0, 4, 8, …; the index is 32-bit, with N ≤ MAX_WORDS so no wrap.
- `word_count` = words acknowledged by memory.
- The byte-within-group counter is 2 bits. It clears on each group completion and on reset.
- No UART reads are issued in WRITE; there is no prefetch.
- Bytes arriving after N words are left in the UART buffer.

## Timing
- Reset values:
  - all outputs 0: `uart_out_valid`, `mem_in_valid`, `mem_in_addr`, `mem_in_data`, `load_completed`, `load_error`, `word_count`.
  - state LEN; byte counter 0; word index 0.
- UART read handshake:
  - `uart_out_valid` is registered. It rises only in LEN or DATA, when `uart_buf_len != 0`, with no outstanding request, and not in the mandatory gap cycle.
  - `uart_out_valid` is held until `uart_out_ready` = 1, which may come in the same or any later cycle. The byte is captured on that edge.
  - `uart_out_valid` is 0 in the following cycle (one-cycle gap), so consecutive requests are at least 2 cycles apart.
  - `uart_out_ready` while `uart_out_valid` = 0 is ignored.
  - With `uart_buf_len` == 0, no request is issued and all state holds indefinitely.
- Memory write handshake:
  - `mem_in_valid` rises the cycle after the 4th data byte is captured.
  - `mem_in_valid`, `mem_in_addr` and `mem_in_data` are held stable until `mem_in_ready` = 1.
  - `mem_in_valid` drops in the next cycle.
- Completion:
  - `load_completed` rises 1 cycle after the last `mem_in_ready`.
  - For N == 0, `load_completed` rises 1 cycle after the 4th length byte.
  - `load_error` rises 1 cycle after the 4th length byte.
  - `load_completed` and `load_error` are never both 1.
- Reset mid-operation:
  - A partial word or length is discarded.
  - Any pending `uart_out_valid` or `mem_in_valid` drops at the reset edge.
  - Every output is at its reset value in the cycle after reset is sampled low.

## Test plan
- **Empty image:** UART delivers 00 00 00 00 → `load_completed` = 1 one cycle after the 4th ready; no `mem_in_valid` pulse; `word_count` = 0.
- **Two-word image:** bytes 02 00 00 00 44 33 22 11 EF BE AD DE → two writes, (addr 0, 0x11223344) then (addr 4, 0xDEADBEEF); `load_completed` one cycle after the 2nd `mem_in_ready`; `word_count` = 2.
- **Buffer starvation:** `uart_buf_len` held at 0 for 50 cycles after 2 data bytes → `uart_out_valid` stays 0 and no write occurs; refilling completes the same word correctly.
- **Memory back-pressure:** `mem_in_ready` delayed 5 cycles → `mem_in_valid`, address and data stay stable for all 5 cycles; no UART request during the wait; exactly one write.
- **Oversize length:** MEM_BIT_WIDTH = 16, N = 0x00004001 → `load_error` = 1, `load_completed` = 0, zero writes, no further `uart_out_valid`.
- **Reset mid-word:** reset low for 1 cycle after 2 of 4 data bytes → all outputs 0 the next cycle; a fresh full stream then loads from addr 0 and completes.
